// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA copy engine: FSM state encoding,
// controller status-word bit positions and the memory beat stride.
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        LOADED,
        WR_REQ,
        COMPLETE,
        ERR
    } copy_state_e;

    localparam int unsigned VALID_LOAD_BIT  = 1;
    localparam int unsigned VALID_STORE_BIT = 2;
    localparam int unsigned VALID_DONE_BIT  = 3;
    localparam int unsigned DONE_BIT        = 0;

    localparam int unsigned BEAT_STRIDE = 4;

endpackage

// File: rtl/dma_word_buf.sv
// Word buffer staging one copy job: synchronous write port, combinational
// read port, both addressed by the engine's beat counter.
module dma_word_buf #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned BUF_DEPTH  = 16,
    parameter int unsigned IDX_W      = 4
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [WORD_WIDTH-1:0] wdata_i,
    output logic [WORD_WIDTH-1:0] rdata_o
);

    logic [WORD_WIDTH-1:0] mem_q [BUF_DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dma_copy_engine.sv
// Executes the copy authorised by the DMA PMP-check controller: reads the
// source into a local buffer on LOAD, writes it out on STORE, reports done.
module dma_copy_engine import dma_pkg::*; #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned BUF_DEPTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] valid_i,
    input  logic [DATA_WIDTH-1:0] length_i,
    input  logic [63:0]           src_addr_i,
    input  logic [63:0]           dst_addr_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [63:0]           mem_addr_o,
    output logic [WORD_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [WORD_WIDTH-1:0] mem_rdata_i,
    output logic [DATA_WIDTH-1:0] done_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int unsigned IdxW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CntW = DATA_WIDTH + 1;

    copy_state_e state_q, state_d;
    logic [1:0]      valid_q;  // {store, load} bits of the previous status word
    logic [IdxW-1:0] k_q, k_d;
    logic            pend_q, pend_d;
    logic            abort_q, abort_d;
    logic            err_q, err_d;
    logic            req_q;
    logic [CntW-1:0] n_q, n_d;
    logic [63:0]     src_q, src_d, dst_q, dst_d;

    logic            load_edge, store_edge, valid_zero, last_beat, buf_we;
    logic [CntW-1:0] n_new;
    logic [63:0]     beat_off;
    logic [WORD_WIDTH-1:0] buf_rdata;

    assign load_edge  = valid_i[VALID_LOAD_BIT]  & ~valid_q[0];
    assign store_edge = valid_i[VALID_STORE_BIT] & ~valid_q[1];
    assign valid_zero = (valid_i == '0);
    // One extra bit keeps length 0xFFFF_FFFF from wrapping N to zero.
    assign n_new      = CntW'(length_i) + CntW'(1);
    assign last_beat  = (CntW'(k_q) == n_q - CntW'(1));
    assign beat_off   = 64'(k_q) * 64'(BEAT_STRIDE);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        pend_d  = pend_q;
        abort_d = abort_q;
        err_d   = err_q;
        n_d     = n_q;
        src_d   = src_q;
        dst_d   = dst_q;
        buf_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                pend_d  = 1'b0;
                abort_d = 1'b0;
                err_d   = 1'b0;
                if (load_edge) begin
                    n_d    = n_new;
                    src_d  = src_addr_i;
                    dst_d  = dst_addr_i;
                    k_d    = '0;
                    pend_d = store_edge;
                    if (n_new > CntW'(BUF_DEPTH)) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = RD_REQ;
                    end
                end else if (store_edge) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else if (valid_i[VALID_DONE_BIT]) begin
                    state_d = COMPLETE;
                end
            end
            RD_REQ: begin
                if (store_edge) pend_d = 1'b1;
                if (valid_zero) abort_d = 1'b1;
                if (mem_gnt_i)  state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (store_edge) pend_d = 1'b1;
                if (valid_zero) abort_d = 1'b1;
                if (mem_rvalid_i) begin
                    buf_we = 1'b1;
                    if (abort_d) begin
                        state_d = IDLE;
                    end else if (last_beat) begin
                        state_d = LOADED;
                    end else begin
                        k_d     = k_q + IdxW'(1);
                        state_d = RD_REQ;
                    end
                end
            end
            LOADED: begin
                if (store_edge || pend_q) begin
                    k_d     = '0;
                    pend_d  = 1'b0;
                    state_d = WR_REQ;
                end else if (valid_i[VALID_DONE_BIT]) begin
                    state_d = COMPLETE;
                end else if (valid_zero) begin
                    state_d = IDLE;
                end
            end
            WR_REQ: begin
                if (valid_zero) abort_d = 1'b1;
                if (mem_gnt_i) begin
                    if (abort_d) begin
                        state_d = IDLE;
                    end else if (last_beat) begin
                        state_d = COMPLETE;
                    end else begin
                        k_d = k_q + IdxW'(1);
                    end
                end
            end
            COMPLETE, ERR: begin
                if (valid_zero) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end else if (state_q == ERR && valid_i[VALID_DONE_BIT]) begin
                    state_d = COMPLETE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            valid_q <= '0;
            k_q     <= '0;
            pend_q  <= 1'b0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= {valid_i[VALID_STORE_BIT], valid_i[VALID_LOAD_BIT]};
            k_q     <= k_d;
            pend_q  <= pend_d;
            abort_q <= abort_d;
            err_q   <= err_d;
            req_q   <= (state_d == RD_REQ) || (state_d == WR_REQ);
        end
    end

    // Job descriptor only matters outside IDLE, so it needs no reset.
    always_ff @(posedge clk_i) begin
        n_q   <= n_d;
        src_q <= src_d;
        dst_q <= dst_d;
    end

    dma_word_buf #(
        .WORD_WIDTH(WORD_WIDTH),
        .BUF_DEPTH (BUF_DEPTH),
        .IDX_W     (IdxW)
    ) u_wbuf (
        .clk_i  (clk_i),
        .we_i   (buf_we),
        .idx_i  (k_q),
        .wdata_i(mem_rdata_i),
        .rdata_o(buf_rdata)
    );

    assign mem_req_o   = req_q;
    assign mem_we_o    = (state_q == WR_REQ);
    assign mem_addr_o  = (state_q == RD_REQ) ? src_q + beat_off :
                         (state_q == WR_REQ) ? dst_q + beat_off : '0;
    assign mem_wdata_o = (state_q == WR_REQ) ? buf_rdata : '0;
    assign done_o      = DATA_WIDTH'((state_q == COMPLETE) || (state_q == ERR)) << DONE_BIT;
    assign busy_o      = (state_q == RD_REQ) || (state_q == RD_WAIT) || (state_q == WR_REQ);
    assign err_o       = err_q;

endmodule

// File: doc/dma_copy_engine.md
# dma_copy_engine

Data mover that sits directly downstream of the DMA PMP-check controller and executes the copy it authorises. It watches the controller's `valid` word. On the LOAD grant it reads `length+1` 32-bit words from the source region into a local buffer. On the STORE grant it writes them to the destination region. It then drives `done` back to the controller so the controller can leave its DONE state.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: width of the control words (`valid_i`, `length_i`, `done_o`).
- `WORD_WIDTH`, default 32: memory data beat width; the address stride is 4 bytes.
- `BUF_DEPTH`, default 16: buffer capacity in words; must be a power of two.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `valid_i`, in, DATA_WIDTH: controller status word. Bit 1 = LOAD granted, bit 2 = STORE granted, bit 3 = DONE. The bits are sticky until the controller returns to idle, at which point the word is 0.
- `length_i`, in, DATA_WIDTH: word count minus one. Sampled on the LOAD edge.
- `src_addr_i`, in, 64: source base, `{src_msb, src_lsb[31:3], 3'b0}`.
- `dst_addr_i`, in, 64: destination base, same format.
- `mem_req_o`, out, 1: memory request.
- `mem_we_o`, out, 1: 1 = write, 0 = read.
- `mem_addr_o`, out, 64: beat address.
- `mem_wdata_o`, out, WORD_WIDTH: write data.
- `mem_gnt_i`, in, 1: request accepted.
- `mem_rvalid_i`, in, 1: read data valid.
- `mem_rdata_i`, in, WORD_WIDTH: read data.
- `done_o`, out, DATA_WIDTH: bit 0 = copy finished or abandoned; all other bits are 0. Connects to the controller's `done_i`.
- `busy_o`, out, 1: the engine is in RD_REQ, RD_WAIT or WR_REQ.
- `err_o`, out, 1: sticky error for the current job. Cleared on return to IDLE.

## Operation
- Edge detection: a registered copy `valid_q` of `valid_i`. `load_edge = valid_i[1] & ~valid_q[1]`. `store_edge = valid_i[2] & ~valid_q[2]`.
- States: IDLE, RD_REQ, RD_WAIT, LOADED, WR_REQ, COMPLETE, ERR.
- IDLE, on `load_edge`:
  - Latch `N = length_i + 1`, computed in DATA_WIDTH+1 bits so that `length_i = 0xFFFFFFFF` gives N = 2^32 and does not wrap to 0.
  - Latch `src_addr_i` and `dst_addr_i`. Clear the beat counter `k`.
  - If `N > BUF_DEPTH`: go to ERR and set `err_o`. Otherwise go to RD_REQ.
- RD_REQ:
  - Drive `mem_req_o = 1`, `mem_we_o = 0`, `mem_addr_o = src + k*4`.
  - Hold `mem_req_o` and `mem_addr_o` stable until `mem_gnt_i`, then go to RD_WAIT.
- RD_WAIT: on `mem_rvalid_i`, write `buf[k] = mem_rdata_i`. If `k == N-1`, go to LOADED; otherwise `k++` and return to RD_REQ.
- LOADED, on `store_edge`: clear `k` and go to WR_REQ.
- WR_REQ:
  - Drive `mem_req_o = 1`, `mem_we_o = 1`, `mem_addr_o = dst + k*4`, `mem_wdata_o = buf[k]`.
  - A write completes on `mem_gnt_i`. On the last beat go to COMPLETE; otherwise `k++`.
- Store without load: `store_edge` in IDLE (source check failed, destination check passed). Go to ERR, set `err_o`, issue no writes.
- `valid_i[3]` seen while in IDLE, LOADED or ERR: go to COMPLETE. This is the denied path, where no store is granted.
- COMPLETE and ERR drive `done_o = 1`. When `valid_i == 0` (controller back in idle), go to IDLE, clear `done_o` and clear `err_o`.
- Abort: `valid_i` falls to 0 while in RD_REQ, RD_WAIT or WR_REQ.
  - The outstanding beat completes: a granted read waits for `rvalid`; a pending request is held until `gnt`.
  - Then go to IDLE with no further beats, no `done_o` pulse, and `err_o` cleared.
- At most one outstanding memory transaction at any time.

## Timing
- Reset values: every output is 0 (`mem_addr_o`, `mem_wdata_o`, `done_o` included). State = IDLE, `valid_q = 0`, buffer contents undefined.
- `mem_req_o` asserts in the cycle after `load_edge` or `store_edge`, and is registered.
- Read beat: 2 cycles minimum (`gnt` in the request cycle, `rvalid` in the next).
- Write beat: 1 cycle minimum (`gnt` in the request cycle).
- `done_o` asserts in the cycle after the final write `gnt`. It deasserts in the cycle after `valid_i` reads 0.
- `load_edge` and `store_edge` in the same cycle: handle the load first. Latch the store in a pending flag and act on it on reaching LOADED.

## Structure
- Package `dma_pkg` holds:
  - the `copy_state_e` enum;
  - bit indices `VALID_LOAD_BIT = 1`, `VALID_STORE_BIT = 2`, `VALID_DONE_BIT = 3`, `DONE_BIT = 0`;
  - the beat stride constant 4.
- Sub-module `dma_word_buf`: BUF_DEPTH × WORD_WIDTH register array with one synchronous write port and one combinational read port, both indexed by `k`.

## Test plan
- `length = 3`, src `0x8000_0000`, dst `0x8000_1000`, LOAD then STORE, zero-wait memory:
  - 4 reads at `0x8000_0000`, `0x8000_0004`, `0x8000_0008`, `0x8000_000C`;
  - then 4 writes of the same data to `0x8000_1000` through `0x8000_100C`;
  - `done_o = 1` one cycle after the last `gnt`; `err_o = 0`.
- `length = 16` with BUF_DEPTH 16: ERR with `err_o = 1`, no memory requests, `done_o = 1` until `valid_i = 0`.
- STORE edge with no prior LOAD: `err_o = 1`, no writes, `done_o = 1`.
- `gnt` delayed 3 cycles on every beat: `mem_req_o` and `mem_addr_o` stay stable throughout; the data written matches the data read.
- `valid_i` cleared while RD_WAIT is pending on beat 1 of 4: after `rvalid` the engine returns to IDLE, beats 2 and 3 are never requested, `done_o` stays 0.
- Asynchronous reset during WR_REQ: all outputs 0 immediately; the next LOAD restarts cleanly from beat 0.
